// File: rtl/tap_bus_pkg.sv
// Shared definitions for the TAP bus sequencer: state encoding, response
// status codes, parameter defaults and the bridge read-data select.
package tap_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RETRY = 3'd3,
        ST_RESP  = 3'd4
    } tap_state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;

    localparam logic [9:0]  TIMEOUT_CYCLES_DEF = 10'd512;
    localparam int unsigned MAX_RETRY_DEF      = 2;

    function automatic logic [31:0] bus_mux(input logic sel, input logic [31:0] ahb_val,
                                            input logic [31:0] apb_val);
        logic [31:0] res;
        if (sel) begin
            res = apb_val;
        end else begin
            res = ahb_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/tap_xfer_watchdog.sv
// Saturating wait-cycle counter with expiry compare for one bridge transfer attempt.
module tap_xfer_watchdog
    import tap_bus_pkg::*;
#(
    parameter logic [9:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [9:0] cnt_r;

    // Wait counter: cleared per attempt, counts while enabled, sticks at 1023.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 10'd0;
        end else if (clear) begin
            cnt_r <= 10'd0;
        end else if (enable && (cnt_r != 10'd1023)) begin
            cnt_r <= cnt_r + 10'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == (TIMEOUT_CYCLES - 10'd1));

endmodule

// File: rtl/tap_bus_sequencer.sv
// Sequences one TAP request onto the AHB or APB bridge, with per-attempt
// timeout, bounded re-issue and a sticky failure flag.
module tap_bus_sequencer
    import tap_bus_pkg::*;
#(
    parameter logic [9:0]  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sel,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        transfer_TAP_AHB,
    output logic        transfer_TAP_APB,
    input  logic        done_AHB_TAP,
    input  logic        done_APB_TAP,
    input  logic [31:0] rdata_AHB,
    input  logic [31:0] rdata_APB,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        timeout_sticky,
    input  logic        timeout_clr
);

    localparam logic [1:0] MAX_RETRY_C = 2'(MAX_RETRY);

    tap_state_t  state_r, state_nxt_s;
    logic        sel_r, sel_eff_s, capture_s, done_sel_s, expired_s, retry_ok_s;
    logic        give_up_s;
    logic [1:0]  retry_r;
    logic        req_ready_r, ahb_pulse_r, apb_pulse_r, rsp_valid_r;
    logic        req_ready_nxt_s, ahb_pulse_nxt_s, apb_pulse_nxt_s, rsp_valid_nxt_s;
    logic        bus_write_r, sticky_r;
    logic [31:0] bus_addr_r, bus_wdata_r, rsp_rdata_r;
    logic [1:0]  rsp_status_r;

    assign capture_s  = (state_r == ST_IDLE) && req_valid;
    assign sel_eff_s  = capture_s ? req_sel : sel_r;
    assign done_sel_s = sel_r ? done_APB_TAP : done_AHB_TAP;
    assign retry_ok_s = (retry_r < MAX_RETRY_C);
    assign give_up_s  = (state_r == ST_WAIT) && !done_sel_s && expired_s && !retry_ok_s;

    tap_xfer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .clear  (state_r == ST_ISSUE),
        .enable (state_r == ST_WAIT),
        .expired(expired_s)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a done in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = req_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (done_sel_s) begin
                    state_nxt_s = ST_RESP;
                end else if (expired_s) begin
                    state_nxt_s = retry_ok_s ? ST_RETRY : ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RETRY: state_nxt_s = ST_ISSUE;
            ST_RESP:  state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs leave a flop.
    always_comb begin
        req_ready_nxt_s = (state_nxt_s == ST_IDLE);
        ahb_pulse_nxt_s = (state_nxt_s == ST_ISSUE) && !sel_eff_s;
        apb_pulse_nxt_s = (state_nxt_s == ST_ISSUE) && sel_eff_s;
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    end

    // Handshake and transfer-pulse output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            ahb_pulse_r <= 1'b0;
            apb_pulse_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= req_ready_nxt_s;
            ahb_pulse_r <= ahb_pulse_nxt_s;
            apb_pulse_r <= apb_pulse_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
        end
    end

    // Request attributes, retry count and response capture.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r        <= 1'b0;
            bus_write_r  <= 1'b0;
            bus_addr_r   <= 32'd0;
            bus_wdata_r  <= 32'd0;
            retry_r      <= 2'd0;
            rsp_rdata_r  <= 32'd0;
            rsp_status_r <= RSP_OK;
        end else if (capture_s) begin
            sel_r       <= req_sel;
            bus_write_r <= req_write;
            bus_addr_r  <= req_addr;
            bus_wdata_r <= req_wdata;
            retry_r     <= 2'd0;
        end else if ((state_r == ST_WAIT) && done_sel_s) begin
            rsp_rdata_r  <= bus_write_r ? 32'd0 : bus_mux(sel_r, rdata_AHB, rdata_APB);
            rsp_status_r <= RSP_OK;
        end else if ((state_r == ST_WAIT) && expired_s && retry_ok_s) begin
            retry_r <= retry_r + 2'd1;
        end else if (give_up_s) begin
            rsp_rdata_r  <= 32'd0;
            rsp_status_r <= RSP_TIMEOUT;
        end else begin
            retry_r <= retry_r;
        end
    end

    // Sticky failure flag; a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (give_up_s) begin
            sticky_r <= 1'b1;
        end else if (timeout_clr) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    assign req_ready        = req_ready_r;
    assign transfer_TAP_AHB = ahb_pulse_r;
    assign transfer_TAP_APB = apb_pulse_r;
    assign rsp_valid        = rsp_valid_r;
    assign bus_write        = bus_write_r;
    assign bus_addr         = bus_addr_r;
    assign bus_wdata        = bus_wdata_r;
    assign rsp_rdata        = rsp_rdata_r;
    assign rsp_status       = rsp_status_r;
    assign timeout_sticky   = sticky_r;

endmodule
